// File: rtl/kda_job_arbiter.sv
// kda_job_arbiter: round-robin arbiter that hands one kda instance to one of
// NUM_REQ requesters per job. A job is IN_BEATS input beats forwarded to kda,
// followed by 4*(chunks+1) result beats routed back to the owning requester.
module kda_job_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int IN_BEATS = 17
) (
    input  logic                       clk_i,
    input  logic                       reset_i,

    input  logic [64*NUM_REQ-1:0]      req_data_i,
    input  logic [NUM_REQ-1:0]         req_v_i,
    output logic [NUM_REQ-1:0]         req_ready_o,

    output logic [63:0]                resp_data_o,
    output logic [NUM_REQ-1:0]         resp_v_o,
    input  logic [NUM_REQ-1:0]         resp_yumi_i,

    output logic [63:0]                kda_data_o,
    output logic                       kda_v_o,
    input  logic                       kda_ready_i,

    input  logic [63:0]                kda_data_i,
    input  logic                       kda_v_i,
    output logic                       kda_yumi_o,

    output logic [$clog2(NUM_REQ)-1:0] grant_o,
    output logic                       busy_o
);

    localparam int GW = $clog2(NUM_REQ);
    localparam int BW = (IN_BEATS > 1) ? $clog2(IN_BEATS) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(IN_BEATS - 1);
    localparam logic [GW:0]   NUM_REQ_W = (GW + 1)'(NUM_REQ);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    // Debug job counters stick at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    state_t         state_q, state_d;
    logic [GW-1:0]  grant_q, grant_d;
    logic [GW-1:0]  rr_ptr_q, rr_ptr_d;
    logic [BW-1:0]  beat_cnt_q, beat_cnt_d;
    logic [3:0]     out_cnt_q, out_cnt_d;
    logic [1:0]     chunks_q, chunks_d;
    logic [15:0]    job_cnt_q [NUM_REQ];
    logic [15:0]    job_cnt_d [NUM_REQ];

    logic           arb_found;
    logic [GW-1:0]  arb_idx;
    logic [GW:0]    arb_cand;
    logic [GW:0]    nxt_sum;
    logic [GW-1:0]  nxt_ptr;
    logic [63:0]    load_beat;
    logic           load_xfer;

    // Circular search for the first requesting index at or after rr_ptr.
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = '0;
        arb_cand  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            arb_cand = {1'b0, rr_ptr_q} + (GW + 1)'(i);
            if (arb_cand >= NUM_REQ_W) begin
                arb_cand = arb_cand - NUM_REQ_W;
            end
            if (!arb_found && req_v_i[arb_cand[GW-1:0]]) begin
                arb_found = 1'b1;
                arb_idx   = arb_cand[GW-1:0];
            end
        end
    end

    // Pointer value that puts the current owner last in the next search.
    always_comb begin
        nxt_sum = {1'b0, grant_q} + {{GW{1'b0}}, 1'b1};
        if (nxt_sum >= NUM_REQ_W) begin
            nxt_sum = nxt_sum - NUM_REQ_W;
        end
        nxt_ptr = nxt_sum[GW-1:0];
    end

    // Granted requester's current beat and whether it moves into kda this cycle.
    always_comb begin
        load_beat = req_data_i[64*grant_q +: 64];
        load_xfer = req_v_i[grant_q] & kda_ready_i;
    end

    // Next-state, counters and handshake outputs; reset forces every output low.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        rr_ptr_d    = rr_ptr_q;
        beat_cnt_d  = beat_cnt_q;
        out_cnt_d   = out_cnt_q;
        chunks_d    = chunks_q;
        job_cnt_d   = job_cnt_q;

        req_ready_o = '0;
        resp_data_o = '0;
        resp_v_o    = '0;
        kda_data_o  = '0;
        kda_v_o     = 1'b0;
        kda_yumi_o  = 1'b0;
        busy_o      = (state_q != ST_IDLE);

        case (state_q)
            ST_IDLE: begin
                if (arb_found) begin
                    grant_d = arb_idx;
                    state_d = ST_LOAD;
                end
            end

            ST_LOAD: begin
                kda_v_o              = req_v_i[grant_q];
                kda_data_o           = load_beat;
                req_ready_o[grant_q] = kda_ready_i;
                if (load_xfer) begin
                    // Header beat carries the result-size field in its top bits.
                    if (beat_cnt_q == '0) begin
                        chunks_d = load_beat[63:62];
                    end
                    if (beat_cnt_q == LAST_BEAT) begin
                        beat_cnt_d = '0;
                        state_d    = ST_WAIT;
                    end else begin
                        beat_cnt_d = beat_cnt_q + 1'b1;
                    end
                end
            end

            ST_WAIT, ST_DRAIN: begin
                resp_data_o       = kda_data_i;
                resp_v_o[grant_q] = kda_v_i;
                kda_yumi_o        = kda_v_i & resp_yumi_i[grant_q];
                if (state_q == ST_WAIT && kda_v_i) begin
                    state_d = ST_DRAIN;
                end
                if (kda_yumi_o) begin
                    // Last result index is 4*(chunks+1)-1 = {chunks, 2'b11}.
                    if (out_cnt_q == {chunks_q, 2'b11}) begin
                        out_cnt_d          = '0;
                        rr_ptr_d           = nxt_ptr;
                        job_cnt_d[grant_q] = sat_inc16(job_cnt_q[grant_q]);
                        state_d            = ST_IDLE;
                    end else begin
                        out_cnt_d = out_cnt_q + 4'd1;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (reset_i) begin
            req_ready_o = '0;
            resp_data_o = '0;
            resp_v_o    = '0;
            kda_data_o  = '0;
            kda_v_o     = 1'b0;
            kda_yumi_o  = 1'b0;
            busy_o      = 1'b0;
        end
    end

    // State and counter registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= ST_IDLE;
            grant_q    <= '0;
            rr_ptr_q   <= '0;
            beat_cnt_q <= '0;
            out_cnt_q  <= '0;
            chunks_q   <= '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                job_cnt_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            rr_ptr_q   <= rr_ptr_d;
            beat_cnt_q <= beat_cnt_d;
            out_cnt_q  <= out_cnt_d;
            chunks_q   <= chunks_d;
            for (int i = 0; i < NUM_REQ; i++) begin
                job_cnt_q[i] <= job_cnt_d[i];
            end
        end
    end

    assign grant_o = grant_q;

endmodule

// File: tb/tb_kda_job_arbiter.sv
// Testbench for kda_job_arbiter: directed scenarios plus randomized jobs,
// checked against a job-level reference (round-robin pointer, beat lists).
module tb_kda_job_arbiter;

    localparam int N  = 4;
    localparam int NB = 17;

    logic            clk = 1'b0;
    logic            reset_i;
    logic [64*N-1:0] req_data_i;
    logic [N-1:0]    req_v_i;
    logic [N-1:0]    req_ready_o;
    logic [63:0]     resp_data_o;
    logic [N-1:0]    resp_v_o;
    logic [N-1:0]    resp_yumi_i;
    logic [63:0]     kda_data_o;
    logic            kda_v_o;
    logic            kda_ready_i;
    logic [63:0]     kda_data_i;
    logic            kda_v_i;
    logic            kda_yumi_o;
    logic [1:0]      grant_o;
    logic            busy_o;

    int n_assert = 0;
    int n_fail   = 0;
    int model_ptr = 0;
    int jobs [N];
    logic [63:0] beats [NB];
    logic [63:0] res [16];

    always #5 clk = ~clk;

    kda_job_arbiter #(.NUM_REQ(N), .IN_BEATS(NB)) dut (
        .clk_i       (clk),
        .reset_i     (reset_i),
        .req_data_i  (req_data_i),
        .req_v_i     (req_v_i),
        .req_ready_o (req_ready_o),
        .resp_data_o (resp_data_o),
        .resp_v_o    (resp_v_o),
        .resp_yumi_i (resp_yumi_i),
        .kda_data_o  (kda_data_o),
        .kda_v_o     (kda_v_o),
        .kda_ready_i (kda_ready_i),
        .kda_data_i  (kda_data_i),
        .kda_v_i     (kda_v_i),
        .kda_yumi_o  (kda_yumi_o),
        .grant_o     (grant_o),
        .busy_o      (busy_o)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int exp_grant(input logic [N-1:0] m);
        for (int i = 0; i < N; i++) begin
            int j;
            j = (model_ptr + i) % N;
            if (m[j]) return j;
        end
        return 0;
    endfunction

    task automatic clear_inputs();
        req_data_i  = '0;
        req_v_i     = '0;
        resp_yumi_i = '0;
        kda_ready_i = 1'b0;
        kda_data_i  = '0;
        kda_v_i     = 1'b0;
    endtask

    task automatic chk_outs_zero(input string tag);
        chk({tag, "_ctl"}, 64'({req_ready_o, resp_v_o, kda_v_o, kda_yumi_o, busy_o}), 64'd0);
        chk({tag, "_resp_data"}, resp_data_o, 64'd0);
        chk({tag, "_kda_data"}, kda_data_o, 64'd0);
    endtask

    task automatic reset_model();
        model_ptr = 0;
        for (int i = 0; i < N; i++) jobs[i] = 0;
    endtask

    task automatic do_reset();
        reset_i = 1'b1;
        clear_inputs();
        repeat (2) begin
            @(negedge clk);
            chk_outs_zero("in_reset");
        end
        @(posedge clk); #1;
        reset_i = 1'b0;
        reset_model();
        @(negedge clk);
        chk_outs_zero("after_reset");
        chk("rst_grant", 64'(grant_o), 64'd0);
        chk("rst_rr_ptr", 64'(dut.rr_ptr_q), 64'd0);
        chk("rst_chunks", 64'(dut.chunks_q), 64'd0);
        @(posedge clk); #1;
    endtask

    // One job for requester r. oth: other requesters' req_v held meanwhile.
    task automatic do_job(input int r, input logic [N-1:0] oth, input bit gaps,
                          input bit tog, input int stall, input bit oy,
                          input logic [1:0] ch, input int exp_n, input bit b2b,
                          input int rst_at);
        logic [N-1:0] oh;
        logic [63:0]  tmp;
        int           idx, n, k, nres;
        bit           v, y, idle_now, exp_kv;
        oh    = '0;
        oh[r] = 1'b1;
        nres  = 4 * (int'(ch) + 1);
        tmp   = {$urandom, $urandom};
        tmp[63:62] = ch;
        beats[0] = tmp;
        for (int i = 1; i < NB; i++) beats[i] = {$urandom, $urandom};
        for (int i = 0; i < nres; i++) res[i] = {$urandom, $urandom};
        for (int i = 0; i < N; i++) if (i != r) req_data_i[64*i +: 64] = {$urandom, $urandom};

        // Input phase
        idx = 0;
        n   = 0;
        while (idx < NB && n < 400) begin
            idle_now = (n == 0) && !b2b;
            v = (n == 0) ? 1'b1 : (gaps ? ($urandom_range(0, 2) != 0) : 1'b1);
            req_v_i = (oth & ~oh) | (v ? oh : '0);
            req_data_i[64*r +: 64] = beats[idx];
            kda_ready_i = tog ? (n % 2 == 0) : 1'b1;
            exp_kv = idle_now ? 1'b0 : v;
            @(negedge clk);
            chk("load_busy", 64'(busy_o), 64'(!idle_now));
            chk("load_kda_v", 64'(kda_v_o), 64'(exp_kv));
            chk("load_ready_others", 64'(req_ready_o & ~oh), 64'd0);
            if (!idle_now) begin
                chk("load_grant", 64'(grant_o), 64'(r));
                chk("load_ready_own", 64'(req_ready_o[r]), 64'(kda_ready_i));
            end
            if (exp_kv && kda_ready_i) begin
                chk("load_data", kda_data_o, beats[idx]);
                idx++;
            end
            @(posedge clk); #1;
            n++;
        end
        chk("load_beats", 64'(idx), 64'(NB));
        if (exp_n > 0) chk("load_cycles", 64'(n), 64'(exp_n));
        req_v_i = oth & ~oh;

        // Result phase
        k = 0;
        n = 0;
        while (k < nres && n < 400) begin
            if (rst_at >= 0 && k == rst_at) break;
            kda_v_i     = 1'b1;
            kda_data_i  = res[k];
            y           = (stall == 0);
            resp_yumi_i = y ? oh : '0;
            if (oy) resp_yumi_i[(r + 1) % N] = 1'b1;
            @(negedge clk);
            chk("resp_v", 64'(resp_v_o), 64'(oh));
            chk("resp_data", resp_data_o, res[k]);
            chk("kda_yumi", 64'(kda_yumi_o), 64'(y));
            chk("res_kda_v", 64'(kda_v_o), 64'd0);
            chk("res_req_ready", 64'(req_ready_o), 64'd0);
            chk("res_busy", 64'(busy_o), 64'd1);
            @(posedge clk); #1;
            if (y) k++;
            else stall--;
            n++;
        end

        if (rst_at >= 0) begin
            chk("pre_reset_beats", 64'(k), 64'(rst_at));
            reset_i = 1'b1;
            @(negedge clk);
            chk_outs_zero("mid_reset");
            @(posedge clk); #1;
            reset_i = 1'b0;
            clear_inputs();
            reset_model();
            @(negedge clk);
            chk_outs_zero("post_abort");
            chk("abort_rr_ptr", 64'(dut.rr_ptr_q), 64'd0);
            chk("abort_grant", 64'(grant_o), 64'd0);
            chk("abort_job_cnt", 64'(dut.job_cnt_q[r]), 64'd0);
            @(posedge clk); #1;
            return;
        end

        chk("res_beats", 64'(k), 64'(nres));
        // Extra beat offered after the job: must not be consumed.
        kda_v_i     = 1'b1;
        kda_data_i  = {$urandom, $urandom};
        resp_yumi_i = '1;
        @(negedge clk);
        jobs[r]++;
        model_ptr = (r + 1) % N;
        chk("post_kda_yumi", 64'(kda_yumi_o), 64'd0);
        chk("post_resp_v", 64'(resp_v_o), 64'd0);
        chk("post_busy", 64'(busy_o), 64'd0);
        chk("post_grant_hold", 64'(grant_o), 64'(r));
        chk("post_rr_ptr", 64'(dut.rr_ptr_q), 64'(model_ptr));
        chk("post_job_cnt", 64'(dut.job_cnt_q[r]), 64'(jobs[r]));
        @(posedge clk); #1;
        kda_v_i     = 1'b0;
        resp_yumi_i = '0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int r;
        reset_i = 1'b1;
        clear_inputs();
        reset_model();
        do_reset();

        // Single job, requester 2, 8 result beats.
        do_job(2, '0, 0, 0, 0, 0, 2'b01, 18, 0, -1);
        chk("single_rr_ptr", 64'(dut.rr_ptr_q), 64'd3);

        // Round-robin with every requester continuously requesting.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            r = exp_grant(4'hF);
            do_job(r, 4'hF, 0, 0, 0, 0, 2'($urandom_range(0, 3)),
                   (i == 0) ? 18 : 17, (i != 0), -1);
        end
        do_reset();

        // Input backpressure and requester gaps.
        r = exp_grant(4'b0010);
        do_job(r, '0, 1, 1, 0, 0, 2'($urandom_range(0, 3)), 0, 0, -1);

        // Output stall with a stray consume strobe from another requester.
        do_job(3, '0, 0, 0, 5, 1, 2'b00, 18, 0, -1);

        // Reset in the middle of result delivery, then a clean job.
        do_job(2, '0, 0, 0, 0, 0, 2'b11, 18, 0, 3);
        do_job(1, '0, 0, 0, 0, 0, 2'($urandom_range(0, 3)), 18, 0, -1);

        // Back-to-back: requester 1 waits while requester 0 finishes.
        r = exp_grant(4'b0011);
        do_job(r, 4'b0010, 0, 0, 0, 0, 2'($urandom_range(0, 3)), 18, 0, -1);
        do_job(1, '0, 0, 0, 0, 0, 2'($urandom_range(0, 3)), 17, 1, -1);

        // Randomized single-requester jobs.
        for (int i = 0; i < 6; i++) begin
            r = $urandom_range(0, N - 1);
            do_job(r, '0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                   2'($urandom_range(0, 3)), 0, 0, -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
